// File: rtl/clk_divn_prog.sv
// clk_divn_prog: runtime-programmable 50%-duty integer clock divider with period tick.
// Define CLK_DIVN_GATE_EN to add the boundary-sampled output enable port en.
module clk_divn_prog #(
  parameter int WIDTH     = 8,
  parameter int DEFAULT_N = 5
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef CLK_DIVN_GATE_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             pend,
  output logic             div_err
);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_N);
  if (DEFAULT_N < 2 || DEFAULT_N > (1 << WIDTH) - 1) begin : g_bad_default
    $error("clk_divn_prog: DEFAULT_N out of range 2..2^WIDTH-1");
  end
  logic [WIDTH-1:0] r_cnt, r_div_cur, r_div_pend, w_cnt_nx, w_div_nx;
  logic             r_pend, r_hi_p, r_hi_n, r_tick, r_err, r_odd, r_en;
  logic             w_bnd, w_en_nx, w_ld_ok, w_en_in;
`ifdef CLK_DIVN_GATE_EN
  assign w_en_in = en;
`else
  assign w_en_in = 1'b1;
`endif
  always_comb begin
    w_bnd    = r_cnt == r_div_cur - 1'b1;
    w_cnt_nx = w_bnd ? '0 : r_cnt + 1'b1;
    w_div_nx = (w_bnd && r_pend) ? r_div_pend : r_div_cur;
    w_en_nx  = w_bnd ? w_en_in : r_en;
    w_ld_ok  = div_load && div_in >= WIDTH'(2);
  end
  // A load in the boundary cycle re-arms pend, so it waits for the following boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= DEF - 1'b1;
      r_div_cur  <= DEF;
      r_div_pend <= '0;
      r_pend     <= 1'b0;
      r_odd      <= DEF[0];
      r_en       <= 1'b1;
      r_hi_p     <= 1'b0;
      r_tick     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nx;
      r_div_cur  <= w_div_nx;
      r_odd      <= w_div_nx[0];
      r_en       <= w_en_nx;
      r_hi_p     <= w_en_nx && (w_cnt_nx < (w_div_nx >> 1));
      r_tick     <= w_en_nx && (w_cnt_nx == '0);
      r_err      <= div_load && div_in < WIDTH'(2);
      r_div_pend <= w_ld_ok ? div_in : r_div_pend;
      r_pend     <= w_ld_ok || (r_pend && !w_bnd);
    end
  end
  // Half-cycle extension for odd divisors; always 0 at a boundary.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) r_hi_n <= 1'b0;
    else          r_hi_n <= r_hi_p;
  end
  assign clk_out = r_odd ? (r_hi_p | r_hi_n) : r_hi_p;
  assign tick    = r_tick;
  assign div_cur = r_div_cur;
  assign pend    = r_pend;
  assign div_err = r_err;
endmodule
